// File: rtl/wb_scoreboard_if.sv
// Bundle of the decode, result-stream and regfile write-port signals around wb_scoreboard.
// The slave modport is the scoreboard itself; the master modport is its environment.
interface wb_scoreboard_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [4:0]       dec_rs1_addr;
  logic [4:0]       dec_rs2_addr;
  logic [4:0]       dec_rd_addr;
  logic             dec_issue;
  logic             dec_long;
  logic             stall;
  logic             alu_valid;
  logic [4:0]       alu_rd_addr;
  logic [XLEN-1:0]  alu_rd_data;
  logic             lr_valid;
  logic             lr_ready;
  logic [4:0]       lr_rd_addr;
  logic [XLEN-1:0]  lr_rd_data;
  logic             rd_wren;
  logic [4:0]       rd_addr;
  logic [XLEN-1:0]  rd_data;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] fifo_count;

  modport slave (
    input  dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_issue, dec_long,
    input  alu_valid, alu_rd_addr, alu_rd_data,
    input  lr_valid, lr_rd_addr, lr_rd_data,
    output stall, lr_ready, rd_wren, rd_addr, rd_data, busy_vec, fifo_count
  );

  modport master (
    output dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_issue, dec_long,
    output alu_valid, alu_rd_addr, alu_rd_data,
    output lr_valid, lr_rd_addr, lr_rd_data,
    input  stall, lr_ready, rd_wren, rd_addr, rd_data, busy_vec, fifo_count
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Regfile write-port arbiter: ALU results go straight through, long-latency results are queued
// in a small FIFO and written into idle slots, with a busy scoreboard stalling RAW/WAW hazards.
module wb_scoreboard #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input logic           clk,
  input logic           rst,
  wb_scoreboard_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } lr_entry_t;

  lr_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;

  lr_entry_t head;
  logic      lr_full;
  logic      push;
  logic      pop;
  logic      alu_win;
  logic      head_wr;
  logic      haz_rs1;
  logic      haz_rs2;
  logic      haz_rd;
  logic      stall_int;
  logic      sb_set;

  // Hazard detection, FIFO handshake and write-port arbitration
  always_comb begin
    head      = mem[rd_ptr];
    lr_full   = (count == CNT_W'(FIFO_DEPTH));
    push      = bus.lr_valid & ~lr_full;
    alu_win   = bus.alu_valid & (bus.alu_rd_addr != 5'd0);
    pop       = ~alu_win & (count != CNT_W'(0));
    head_wr   = pop & (head.addr != 5'd0);
    haz_rs1   = (bus.dec_rs1_addr != 5'd0) & busy[bus.dec_rs1_addr];
    haz_rs2   = (bus.dec_rs2_addr != 5'd0) & busy[bus.dec_rs2_addr];
    haz_rd    = (bus.dec_rd_addr  != 5'd0) & busy[bus.dec_rd_addr];
    stall_int = bus.dec_issue & (haz_rs1 | haz_rs2 | haz_rd);
    sb_set    = bus.dec_issue & bus.dec_long & ~stall_int & (bus.dec_rd_addr != 5'd0);
  end

  // Scoreboard update: clear on drain, then set so a same-index set wins
  always_comb begin
    busy_nxt = busy;
    if (head_wr) busy_nxt[head.addr] = 1'b0;
    if (sb_set)  busy_nxt[bus.dec_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign bus.stall      = stall_int;
  assign bus.lr_ready   = ~lr_full;
  assign bus.busy_vec   = busy;
  assign bus.fifo_count = count;

  // FIFO storage has no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.lr_rd_addr, data: bus.lr_rd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      busy        <= '0;
      bus.rd_wren <= 1'b0;
      bus.rd_addr <= '0;
      bus.rd_data <= '0;
    end else begin
      busy        <= busy_nxt;
      bus.rd_wren <= alu_win | head_wr;
      if (alu_win) begin
        bus.rd_addr <= bus.alu_rd_addr;
        bus.rd_data <= bus.alu_rd_data;
      end else if (head_wr) begin
        bus.rd_addr <= head.addr;
        bus.rd_data <= head.data;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard: reset, ALU path, RAW/WAW stalls,
// arbitration priority, FIFO full and pointer wrap.
module tb_wb_scoreboard;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_scoreboard_if #(.XLEN(32), .FIFO_DEPTH(4)) bus ();

  wb_scoreboard #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.dec_rs1_addr = '0; bus.dec_rs2_addr = '0; bus.dec_rd_addr = '0;
    bus.dec_issue = 1'b0; bus.dec_long = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd_addr = '0; bus.alu_rd_data = '0;
    bus.lr_valid = 1'b0; bus.lr_rd_addr = '0; bus.lr_rd_data = '0;
    step(); step();
    rst = 1'b0;
    chk("por_wren", 64'(bus.rd_wren), 64'd0);
    chk("por_addr", 64'(bus.rd_addr), 64'd0);
    chk("por_count", 64'(bus.fifo_count), 64'd0);
    chk("por_ready", 64'(bus.lr_ready), 64'd1);

    // Fill 3 entries behind a busy ALU and reserve x2, then reset mid-operation
    bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd9; bus.alu_rd_data = 32'h1;
    bus.lr_valid = 1'b1; bus.lr_rd_addr = 5'd1; bus.lr_rd_data = 32'd11;
    bus.dec_issue = 1'b1; bus.dec_long = 1'b1; bus.dec_rd_addr = 5'd2;
    step();
    bus.dec_issue = 1'b0; bus.dec_long = 1'b0; bus.dec_rd_addr = 5'd0;
    bus.lr_rd_addr = 5'd2; bus.lr_rd_data = 32'd22;
    step();
    bus.lr_rd_addr = 5'd3; bus.lr_rd_data = 32'd33;
    step();
    bus.lr_valid = 1'b0;
    chk("pre_rst_count", 64'(bus.fifo_count), 64'd3);
    chk("pre_rst_busy", 64'(bus.busy_vec), 64'h4);
    rst = 1'b1; bus.alu_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_wren", 64'(bus.rd_wren), 64'd0);
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("rst_ready", 64'(bus.lr_ready), 64'd1);
    step();
    chk("rst_no_drain", 64'(bus.rd_wren), 64'd0);

    // ALU only, then ALU to x0 leaves port idle with last addr/data held
    bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd5; bus.alu_rd_data = 32'hDEADBEEF;
    step();
    chk("alu_wren", 64'(bus.rd_wren), 64'd1);
    chk("alu_addr", 64'(bus.rd_addr), 64'd5);
    chk("alu_data", 64'(bus.rd_data), 64'hDEADBEEF);
    bus.alu_rd_addr = 5'd0; bus.alu_rd_data = 32'h55;
    step();
    chk("alu_x0_wren", 64'(bus.rd_wren), 64'd0);
    chk("alu_x0_hold_addr", 64'(bus.rd_addr), 64'd5);
    chk("alu_x0_hold_data", 64'(bus.rd_data), 64'hDEADBEEF);
    bus.alu_valid = 1'b0;

    // Long op to x7, RAW stall on rs1, drain clears busy and stall together
    bus.dec_issue = 1'b1; bus.dec_long = 1'b1; bus.dec_rd_addr = 5'd7;
    #1 chk("long7_nostall", 64'(bus.stall), 64'd0);
    step();
    chk("long7_busy", 64'(bus.busy_vec), 64'h80);
    bus.dec_long = 1'b0; bus.dec_rd_addr = 5'd1; bus.dec_rs1_addr = 5'd7;
    #1 chk("raw_stall", 64'(bus.stall), 64'd1);
    bus.lr_valid = 1'b1; bus.lr_rd_addr = 5'd7; bus.lr_rd_data = 32'h1234;
    step();
    bus.lr_valid = 1'b0;
    chk("raw_push_count", 64'(bus.fifo_count), 64'd1);
    chk("raw_no_bypass", 64'(bus.rd_wren), 64'd0);
    chk("raw_still_stall", 64'(bus.stall), 64'd1);
    step();
    chk("raw_wren", 64'(bus.rd_wren), 64'd1);
    chk("raw_addr", 64'(bus.rd_addr), 64'd7);
    chk("raw_data", 64'(bus.rd_data), 64'h1234);
    chk("raw_busy_clr", 64'(bus.busy_vec), 64'd0);
    chk("raw_count", 64'(bus.fifo_count), 64'd0);
    #1 chk("raw_stall_drop", 64'(bus.stall), 64'd0);
    bus.dec_issue = 1'b0; bus.dec_rs1_addr = 5'd0; bus.dec_rd_addr = 5'd0;

    // Arbitration: ALU owns the port while two long results wait
    bus.alu_valid = 1'b1; bus.alu_rd_addr = 5'd9; bus.alu_rd_data = 32'h99;
    bus.lr_valid = 1'b1; bus.lr_rd_addr = 5'd3; bus.lr_rd_data = 32'hA;
    step();
    bus.lr_rd_addr = 5'd4; bus.lr_rd_data = 32'hB;
    step();
    bus.lr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arb_alu_addr", 64'(bus.rd_addr), 64'd9);
      chk("arb_alu_count", 64'(bus.fifo_count), 64'd2);
    end
    bus.alu_valid = 1'b0;
    step();
    chk("arb_x3_addr", 64'(bus.rd_addr), 64'd3);
    chk("arb_x3_data", 64'(bus.rd_data), 64'hA);
    chk("arb_x3_count", 64'(bus.fifo_count), 64'd1);
    step();
    chk("arb_x4_addr", 64'(bus.rd_addr), 64'd4);
    chk("arb_x4_data", 64'(bus.rd_data), 64'hB);
    chk("arb_x4_count", 64'(bus.fifo_count), 64'd0);
    step();
    chk("arb_idle", 64'(bus.rd_wren), 64'd0);

    // Fill to full behind the ALU; extra offers are refused
    bus.alu_valid = 1'b1;
    bus.lr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.lr_rd_addr = 5'(10 + i); bus.lr_rd_data = 32'(32'h100 + i);
      step();
      chk("fill_count", 64'(bus.fifo_count), 64'(i + 1));
    end
    chk("full_ready", 64'(bus.lr_ready), 64'd0);
    bus.lr_rd_addr = 5'd20; bus.lr_rd_data = 32'hBAD;
    step();
    chk("full_ignore_count", 64'(bus.fifo_count), 64'd4);
    bus.lr_valid = 1'b0; bus.alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_drain_addr", 64'(bus.rd_addr), 64'(10 + i));
      chk("full_drain_data", 64'(bus.rd_data), 64'(32'h100 + i));
    end
    chk("full_empty", 64'(bus.fifo_count), 64'd0);

    // Six more back-to-back across the pointer wrap
    bus.lr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.lr_rd_addr = 5'(14 + i); bus.lr_rd_data = 32'(32'h200 + i);
      step();
      chk("wrap_count", 64'(bus.fifo_count), 64'd1);
      if (i > 0) begin
        chk("wrap_addr", 64'(bus.rd_addr), 64'(14 + i - 1));
        chk("wrap_data", 64'(bus.rd_data), 64'(32'h200 + i - 1));
      end
    end
    bus.lr_valid = 1'b0;
    step();
    chk("wrap_last_addr", 64'(bus.rd_addr), 64'd19);
    chk("wrap_last_data", 64'(bus.rd_data), 64'h205);
    chk("wrap_last_count", 64'(bus.fifo_count), 64'd0);

    // WAW on x8, rs2 hazard, and x0 never reserved or hazarded
    bus.dec_issue = 1'b1; bus.dec_long = 1'b1; bus.dec_rd_addr = 5'd8;
    step();
    bus.dec_long = 1'b0;
    #1 chk("waw_stall", 64'(bus.stall), 64'd1);
    bus.dec_rd_addr = 5'd0; bus.dec_rs2_addr = 5'd8;
    #1 chk("rs2_stall", 64'(bus.stall), 64'd1);
    bus.dec_issue = 1'b0;
    #1 chk("no_issue_no_stall", 64'(bus.stall), 64'd0);
    bus.dec_issue = 1'b1; bus.dec_long = 1'b1; bus.dec_rs2_addr = 5'd0; bus.dec_rd_addr = 5'd0;
    #1 chk("x0_long_nostall", 64'(bus.stall), 64'd0);
    step();
    chk("x0_no_busy", 64'(bus.busy_vec), 64'h100);
    bus.dec_long = 1'b0; bus.dec_rs1_addr = 5'd0;
    #1 chk("x0_rs1_nostall", 64'(bus.stall), 64'd0);
    bus.dec_issue = 1'b0;

    // Long result to x0 pops silently; then x8 drains and frees its bit
    bus.lr_valid = 1'b1; bus.lr_rd_addr = 5'd0; bus.lr_rd_data = 32'hFFFF;
    step();
    bus.lr_rd_addr = 5'd8; bus.lr_rd_data = 32'h88;
    step();
    bus.lr_valid = 1'b0;
    chk("lr_x0_wren", 64'(bus.rd_wren), 64'd0);
    chk("lr_x0_count", 64'(bus.fifo_count), 64'd1);
    step();
    chk("x8_wren", 64'(bus.rd_wren), 64'd1);
    chk("x8_addr", 64'(bus.rd_addr), 64'd8);
    chk("x8_data", 64'(bus.rd_data), 64'h88);
    chk("x8_busy_clr", 64'(bus.busy_vec), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Client-side writer for the 32x32 register file write port (rd_addr / rd_wren / rd_data); it merges two result streams into that single port.
- Single-cycle ALU results are written directly. Long-latency results (load, mul/div) are buffered in a FIFO and written into idle slots.
- A per-register busy scoreboard tracks long ops in flight and raises a decode stall on RAW and WAW hazards.
- Sits between execute/memory units and the regfile in the single-cycle core.

Parameters:
- FIFO_DEPTH, 4, entries in the long-result buffer (power of 2, >=2)
- XLEN, 32, data width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- dec_rs1_addr  input  5  source 1 of instruction in decode
- dec_rs2_addr  input  5  source 2 of instruction in decode
- dec_rd_addr  input  5  destination of instruction in decode
- dec_issue  input  1  decode instruction issues this cycle (only honoured when stall=0)
- dec_long  input  1  issuing instruction is long-latency (reserves rd)
- stall  output  1  combinational hazard stall to decode
- alu_valid  input  1  ALU result valid
- alu_rd_addr  input  5  ALU destination
- alu_rd_data  input  XLEN  ALU result
- lr_valid  input  1  long result offered
- lr_ready  output  1  FIFO can accept (= not full)
- lr_rd_addr  input  5  long result destination
- lr_rd_data  input  XLEN  long result
- rd_wren  output  1  regfile write enable (registered)
- rd_addr  output  5  regfile write address (registered)
- rd_data  output  XLEN  regfile write data (registered)
- busy_vec  output  32  scoreboard bits, bit0 always 0
- fifo_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - rd_wren=0, rd_addr=0, rd_data=0, busy_vec=0.
  - FIFO emptied: fifo_count=0, lr_ready=1.
  - Reset mid-operation discards all buffered results and busy bits.
- stall (combinational): dec_issue & (H_rs1 | H_rs2 | H_rd), where
  - H_rs1 = rs1 != 0 & busy[rs1]
  - H_rs2 = rs2 != 0 & busy[rs2]
  - H_rd = rd != 0 & busy[rd] (WAW)
  - No hazard is ever raised for x0.
- Scoreboard set: on dec_issue & dec_long & !stall & dec_rd_addr != 0, busy[dec_rd_addr] is set at the next edge.
- Scoreboard clear: when a FIFO entry is drained to the write port, busy[entry.rd] is cleared at the same edge that rd_wren rises.
  - Set and clear of the same index in one cycle cannot occur, because WAW forces stall.
  - If both events occur anyway, set wins.
- FIFO accept: lr_valid & lr_ready pushes {addr, data} at the edge. lr_ready = fifo_count < FIFO_DEPTH.
  - Push and pop in the same cycle while full is not allowed: lr_ready is 0 when full, even if a pop is occurring.
- Write port arbitration (per cycle, registered into rd_* at the next edge):
  1. alu_valid & alu_rd_addr != 0: rd_wren=1, rd_addr/rd_data = ALU values. The FIFO does not pop.
  2. else if FIFO non-empty: pop head; rd_wren=1, rd_* = head. If head.rd == 0, rd_wren=0 but the entry still pops.
  3. else rd_wren=0. rd_addr and rd_data hold their last value.
- Latency:
  - ALU result to regfile write: 1 cycle.
  - Long result to regfile write: >=2 cycles (push edge, then a pop cycle), more while the ALU occupies the port.
- Simultaneous push into empty FIFO with no ALU write: the entry is not popped in the same cycle (no bypass). It pops next cycle.
- Order: FIFO results drain in arrival order. Wrap-around of the read/write pointers is modulo FIFO_DEPTH.
- Results are not forwarded to decode; they are visible only after the regfile write.

Test Plan:
- Reset: rst=1 for 2 cycles with FIFO holding 3 entries -> rd_wren=0, fifo_count=0, busy_vec=0, lr_ready=1.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle rd_wren=1, rd_addr=5, rd_data=0xDEADBEEF. Repeat with rd=0 -> rd_wren=0.
- Long op RAW:
  - Issue long to x7 -> busy_vec[7]=1.
  - Decode rs1=7 -> stall=1.
  - Push lr rd=7, data=0x1234 -> drains the cycle after push; rd_wren=1, rd_addr=7, busy_vec[7]=0 at the same edge; stall drops.
- Arbitration:
  - FIFO holds x3=0xA, x4=0xB; alu_valid held 3 cycles to x9 -> three ALU writes first, then x3, then x4.
  - fifo_count goes 2,2,2,1,0.
- Full/wrap:
  - Push 4 entries with ALU busy -> lr_ready=0, fifo_count=4.
  - Further lr_valid is ignored.
  - Release ALU -> 4 writes in order; then push 6 more across the pointer wrap; all written in order, data intact.
- WAW and x0:
  - Issue long to x8, then decode rd=8 -> stall=1.
  - Issue long to x0 -> no busy bit; decode rs1=0 -> stall=0.
